// File: rtl/debounce_bank_if.sv
// debounce_bank_if: raw pin levels in, debounced levels and edge events out.
interface debounce_bank_if #(parameter int N_CH = 4);
   logic [N_CH-1:0] i_d, o_q, o_rise, o_fall, o_busy;
   modport master (output i_d, input o_q, o_rise, o_fall, o_busy);
   modport slave (input i_d, output o_q, o_rise, o_fall, o_busy);
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop sync plus tick-qualified debounce FSM.
// Channels share one free-running prescaler; a change is accepted after STABLE_TICKS ticks.
module debounce_bank #(
   parameter int              N_CH         = 4,
   parameter logic [N_CH-1:0] DEFAULT_D    = '0,
   parameter int              TICK_CYCLES  = 300000,
   parameter int              STABLE_TICKS = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   debounce_bank_if.slave  bus
);
   localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
   localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
   typedef enum logic {STABLE, QUAL} state_t;
   logic [N_CH-1:0] s1, s, q, q_nx, rise, rise_nx, fall, fall_nx, busy;
   logic [PW-1:0]   pcnt;
   logic            tick;
   state_t          st [N_CH];
   state_t          st_nx [N_CH];
   logic [CW-1:0]   cnt [N_CH];
   logic [CW-1:0]   cnt_nx [N_CH];
   assign tick = pcnt == PW'(TICK_CYCLES - 1);
   // A bounce-back is checked before the tick so a same-cycle tick is never counted.
   always_comb begin
      st_nx   = st;
      cnt_nx  = cnt;
      q_nx    = q;
      rise_nx = '0;
      fall_nx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (st[i] == STABLE) begin
            if (s[i] != q[i]) begin
               st_nx[i]  = QUAL;
               cnt_nx[i] = '0;
            end
         end else if (st[i] == QUAL) begin
            if (s[i] == q[i]) begin
               st_nx[i]  = STABLE;
               cnt_nx[i] = '0;
            end else if (tick) begin
               if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
                  q_nx[i]    = s[i];
                  rise_nx[i] = s[i];
                  fall_nx[i] = ~s[i];
                  st_nx[i]   = STABLE;
                  cnt_nx[i]  = '0;
               end else begin
                  cnt_nx[i] = cnt[i] + 1'b1;
               end
            end
         end else begin
            st_nx[i]  = STABLE;
            cnt_nx[i] = '0;
         end
      end
   end
   always_comb begin
      busy = '0;
      for (int i = 0; i < N_CH; i++) busy[i] = st[i] == QUAL;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= DEFAULT_D;
         s    <= DEFAULT_D;
         pcnt <= '0;
         q    <= DEFAULT_D;
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < N_CH; i++) begin
            st[i]  <= STABLE;
            cnt[i] <= '0;
         end
      end else begin
         s1   <= bus.i_d;
         s    <= s1;
         pcnt <= tick ? '0 : pcnt + 1'b1;
         q    <= q_nx;
         rise <= rise_nx;
         fall <= fall_nx;
         for (int i = 0; i < N_CH; i++) begin
            st[i]  <= st_nx[i];
            cnt[i] <= cnt_nx[i];
         end
      end
   end
   assign bus.o_q    = q;
   assign bus.o_rise = rise;
   assign bus.o_fall = fall;
   assign bus.o_busy = busy;
endmodule
